mul_iter: RTL

//   Parametrised iterative shift-add multiplier for the integer core's M-extension path.

---
 rtl/mul_iter_if.sv | 31 +++
 rtl/mul_iter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mul_iter_if.sv
// mul_iter_if: request/result bundle of the iterative multiplier.
//   req_i    : start request (sampled only while idle)
//   op_i     : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a_i, b_i : multiplicand / multiplier
//   kill_i   : synchronous abort of the in-flight operation
//   busy_o   : operation accepted and not yet retired
//   done_o   : one-cycle pulse, result_o valid
//   result_o : selected product half, held until the next done_o
// The slave modport is the multiplier side, master is the requester side.
interface mul_iter_if #(
  parameter int XLEN = 32
);
  logic            req_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            kill_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output req_i, op_i, a_i, b_i, kill_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  req_i, op_i, a_i, b_i, kill_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
//   Operands are reduced to magnitudes plus a result sign on accept, the
//   unsigned product is built STEP multiplier bits per cycle, and the sign
//   is applied once in FIN. A zero operand skips the iteration entirely.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : mul_iter_if.slave (req_i, op_i, a_i, b_i, kill_i in;
//           busy_o, done_o, result_o out)
// Parameters:
//   XLEN : operand/result width (even, >= 8)
//   STEP : multiplier bits per CALC cycle (power of two dividing XLEN)
module mul_iter #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input logic        clk_i,
  input logic        rst_i,
  mul_iter_if.slave  bus
);

  localparam int N     = XLEN / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W = 2 * XLEN + STEP;
  localparam int HI_W  = XLEN + STEP;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Two's-complement magnitude; -2^(XLEN-1) maps to 2^(XLEN-1) exactly
  // because the result is read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                input logic            is_signed);
    return (is_signed && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p,
                                                   input logic              neg);
    return neg ? (~p + (2*XLEN)'(1)) : p;
  endfunction

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [XLEN-1:0]   a_mag_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN-1:0]   a_mag_d;
  logic [XLEN-1:0]   b_mag_d;
  logic              neg_d;
  logic              zero_op;
  logic [STEP-1:0]   digit;
  logic [HI_W-1:0]   partial;
  logic [HI_W-1:0]   hi_sum;
  logic [2*XLEN-1:0] prod;

  // Operand decode for the accept edge.
  always_comb begin
    a_sgn   = (bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU);
    b_sgn   = (bus.op_i == OP_MULH);
    a_mag_d = magnitude(bus.a_i, a_sgn);
    b_mag_d = magnitude(bus.b_i, b_sgn);
    neg_d   = (a_sgn & bus.a_i[XLEN-1]) ^ (b_sgn & bus.b_i[XLEN-1]);
    zero_op = (bus.a_i == '0) || (bus.b_i == '0);
  end

  // One CALC iteration: the low STEP bits of acc (the next multiplier
  // digit) scale |a| into the high part, then everything shifts right.
  // The high part is STEP bits wider than XLEN so the carry is kept.
  always_comb begin
    digit   = acc_q[STEP-1:0];
    partial = {{STEP{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, digit};
    hi_sum  = acc_q[ACC_W-1:XLEN] + partial;
    acc_d   = {hi_sum, acc_q[XLEN-1:0]} >> STEP;
    prod    = apply_sign(acc_q[2*XLEN-1:0], neg_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_mag_q  <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // kill_i suppresses a request arriving in the same cycle.
          if (bus.req_i && !bus.kill_i) begin
            op_q    <= bus.op_i;
            a_mag_q <= a_mag_d;
            neg_q   <= neg_d;
            cnt_q   <= CNT_W'(N - 1);
            busy_q  <= 1'b1;
            if (zero_op) begin
              acc_q   <= '0;
              state_q <= S_FIN;
            end else begin
              acc_q   <= {{HI_W{1'b0}}, b_mag_d};
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.kill_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
              state_q <= S_FIN;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!bus.kill_i) begin
            result_q <= (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            done_q   <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule
